// File: rtl/lv_frame_scheduler.sv
// Frame pacer and note snapshot buffer in front of the linear visualizer driver.
// Optional feature: define LV_REPEAT_FRAME_EN to re-render the current bank on every idle tick.
module lv_frame_scheduler #(
  parameter int BIN_QTY        = 12,
  parameter int NOTE_W         = 8,
  parameter int FREQ           = 12_000_000,
  parameter int FRAME_HZ       = 60,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BIN_QTY-1:0][NOTE_W-1:0]   notesIn,
  input  logic                             notesInValid,
  input  logic                             clrErr,
  input  logic                             lvDone,
  output logic [BIN_QTY-1:0][NOTE_W-1:0]   notesOut,
  output logic                             lvStart,
  output logic                             busy,
  output logic [7:0]                       overrunCount,
  output logic                             timeoutErr,
  output logic [1:0]                       dbg_state
);

  localparam int PERIOD = FREQ / FRAME_HZ;
  localparam int CW     = $clog2(PERIOD);
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                            state_q, state_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [TW-1:0]                     to_q, to_d;
  logic                              pending_q, pending_d;
  logic [BIN_QTY-1:0][NOTE_W-1:0]    shadow_q, shadow_d;
  logic [BIN_QTY-1:0][NOTE_W-1:0]    bank_q, bank_d;
  logic                              start_q, start_d;
  logic                              busy_q, busy_d;
  logic [7:0]                        ovr_q, ovr_d;
  logic                              terr_q, terr_d;
  logic                              tick, frame_req, load, timeout_hit;

  assign tick = (cnt_q == CW'(PERIOD - 1));

`ifdef LV_REPEAT_FRAME_EN
  assign frame_req = 1'b1;
`else
  // A same-cycle write counts as pending so the bypass path can service it.
  assign frame_req = pending_q | notesInValid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      bank_q    <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      bank_q    <= bank_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      terr_q    <= terr_d;
    end
  end

  // lvStart is a one-cycle request; lvDone is only honoured while in WAIT,
  // and a missing lvDone is bounded by the timeout counter.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && frame_req) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (lvDone) begin
          state_d = S_IDLE;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d   = (state_d == S_START);
    busy_d    = (state_d != S_IDLE);
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    shadow_d  = notesInValid ? notesIn : shadow_q;
    bank_d    = bank_q;
    pending_d = pending_q;
    if (load) begin
      bank_d    = notesInValid ? notesIn : shadow_q;
      pending_d = 1'b0;
    end else if (notesInValid) begin
      pending_d = 1'b1;
    end
    to_d = to_q;
    if (state_q == S_START) begin
      to_d = '0;
    end else if (state_q == S_WAIT) begin
      to_d = to_q + TW'(1);
    end
    ovr_d = ovr_q;
    if (clrErr) begin
      ovr_d = '0;
    end else if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
    terr_d = terr_q;
    if (clrErr) begin
      terr_d = 1'b0;
    end else if (timeout_hit) begin
      terr_d = 1'b1;
    end
  end

  assign notesOut     = bank_q;
  assign lvStart      = start_q;
  assign busy         = busy_q;
  assign overrunCount = ovr_q;
  assign timeoutErr   = terr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lv_frame_scheduler.sv
// Directed bench for lv_frame_scheduler: frame loads are scoreboarded against an
// expected queue of (notes, start cycle) pairs; a driver model answers lvStart.
module tb_lv_frame_scheduler;

  localparam int BIN_QTY = 12;
  localparam int NOTE_W  = 8;
  localparam int NW      = BIN_QTY * NOTE_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] notesIn;
  logic          notesInValid;
  logic          clrErr;
  logic          lvDone;
  logic [NW-1:0] notesOut;
  logic          lvStart;
  logic          busy;
  logic [7:0]    overrunCount;
  logic          timeoutErr;
  logic [1:0]    dbg_state;

  lv_frame_scheduler #(
    .BIN_QTY(BIN_QTY), .NOTE_W(NOTE_W), .FREQ(1000), .FRAME_HZ(100), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .notesIn(notesIn), .notesInValid(notesInValid),
    .clrErr(clrErr), .lvDone(lvDone), .notesOut(notesOut), .lvStart(lvStart),
    .busy(busy), .overrunCount(overrunCount), .timeoutErr(timeoutErr),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [NW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            dly = 5;
  int            done_at = -1;
  bit            watch_a2 = 1'b0;
  logic [NW-1:0] pat_a, pat_a2, pat_b, pat_c, pat_d, pat_e, pat_f, pat_g, pat_h;

  function automatic logic [NW-1:0] mk_pat(input int id);
    logic [NW-1:0] p;
    for (int b = 0; b < BIN_QTY; b++) p[b*NOTE_W +: NOTE_W] = NOTE_W'($urandom_range(0, 255));
    p[NOTE_W-1:0] = NOTE_W'(id);
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
    n_cmp++;
    assert (obs !== bad) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected_not=%0h", tag, obs, bad);
    end
  endtask

  task automatic push_exp(input logic [NW-1:0] d, input int c);
    exp_q.push_back(d);
    exp_cyc_q.push_back(c);
  endtask

  // One cycle: clear strobes, score any start, run the driver model.
  task automatic step();
    logic [NW-1:0] d;
    int            c;
    @(negedge clk);
    cyc++;
    notesInValid = 1'b0;
    clrErr       = 1'b0;
    if (lvStart === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 128'(cyc), 128'(-1));
      end else begin
        d = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("start_notes", 128'(notesOut), 128'(d));
        check("start_cycle", 128'(cyc), 128'(c));
      end
      done_at = (dly > 0) ? cyc + dly : -1;
    end
    if (watch_a2) check_ne("a_never_shown", 128'(notesOut), 128'(pat_a2));
    lvDone = (cyc == done_at);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic write(input logic [NW-1:0] d);
    notesIn      = d;
    notesInValid = 1'b1;
  endtask

  initial begin
    rst = 1'b0; notesIn = '0; notesInValid = 1'b0; clrErr = 1'b0; lvDone = 1'b0;
    pat_a = mk_pat(1); pat_a2 = mk_pat(2); pat_b = mk_pat(3); pat_c = mk_pat(4);
    pat_d = mk_pat(5); pat_e = mk_pat(6); pat_f = mk_pat(7); pat_g = mk_pat(8);
    pat_h = mk_pat(9);

    repeat (2) @(negedge clk);
    check("rst_notesOut", 128'(notesOut), 128'(0));
    check("rst_lvStart", 128'(lvStart), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_overrun", 128'(overrunCount), 128'(0));
    check("rst_timeoutErr", 128'(timeoutErr), 128'(0));
    rst = 1'b1;
    cyc = 0;
    check("c0_state", 128'(dbg_state), 128'(0));

    // Basic frame: write at 3, tick at 9, start at 10, done at 15.
    step_to(3); write(pat_a); push_exp(pat_a, 10);
    step_to(9);  check("c9_notesOut", 128'(notesOut), 128'(0));
    check("c9_busy", 128'(busy), 128'(0));
    step_to(10); check("c10_busy", 128'(busy), 128'(1));
    step_to(15); check("c15_busy", 128'(busy), 128'(1));
    step_to(16); check("c16_busy", 128'(busy), 128'(0));
    check("c16_overrun", 128'(overrunCount), 128'(0));
    check("c16_notesOut", 128'(notesOut), 128'(pat_a));
`ifdef LV_REPEAT_FRAME_EN
    push_exp(pat_a, 20);
`endif

    // Last write wins.
    step_to(22); watch_a2 = 1'b1; write(pat_a2);
    step_to(25); write(pat_b); push_exp(pat_b, 30);
    step_to(29); check("c29_notesOut", 128'(notesOut), 128'(pat_a));

    // Bypass on the tick cycle.
    step_to(39); write(pat_c); push_exp(pat_c, 40);
`ifdef LV_REPEAT_FRAME_EN
    push_exp(pat_c, 50);
`endif
    step_to(50); check("c50_notesOut", 128'(notesOut), 128'(pat_c));

    // Overrun: driver holds the frame for 15 cycles.
    step_to(52); write(pat_d); push_exp(pat_d, 60); dly = 15;
    step_to(69); check("c69_overrun", 128'(overrunCount), 128'(0));
    step_to(70); check("c70_overrun", 128'(overrunCount), 128'(1)); dly = 5;
    step_to(72); write(pat_e); push_exp(pat_e, 80);
    step_to(79); check("c79_notesOut", 128'(notesOut), 128'(pat_d));
`ifdef LV_REPEAT_FRAME_EN
    push_exp(pat_e, 90);
`endif

    // Timeout: driver never answers; WAIT entered at 101.
    step_to(92); write(pat_f); push_exp(pat_f, 100);
    step_to(95); dly = 0;
    step_to(120); check("c120_timeoutErr", 128'(timeoutErr), 128'(0));
    check("c120_state", 128'(dbg_state), 128'(2));
    step_to(121); check("c121_timeoutErr", 128'(timeoutErr), 128'(1));
    check("c121_state", 128'(dbg_state), 128'(0));
    check("c121_busy", 128'(busy), 128'(0));
    check("c121_overrun", 128'(overrunCount), 128'(3));
    step_to(125); check("c125_timeoutErr", 128'(timeoutErr), 128'(1)); clrErr = 1'b1;
    step_to(126); check("c126_timeoutErr", 128'(timeoutErr), 128'(0));
    check("c126_overrun", 128'(overrunCount), 128'(0)); dly = 5;
`ifdef LV_REPEAT_FRAME_EN
    push_exp(pat_f, 130);
`endif

    // Clear beats a same-cycle overrun increment.
    step_to(132); write(pat_g); push_exp(pat_g, 140);
    step_to(135); dly = 15;
    step_to(149); clrErr = 1'b1;
    step_to(150); check("c150_overrun", 128'(overrunCount), 128'(0));
    check("c150_busy", 128'(busy), 128'(1)); dly = 5;

    // Idle ticks without new data.
`ifdef LV_REPEAT_FRAME_EN
    push_exp(pat_g, 160);
    push_exp(pat_g, 170);
`endif
    step_to(170); check("c170_notesOut", 128'(notesOut), 128'(pat_g));

    // Reset mid-WAIT.
    step_to(172); write(pat_h); push_exp(pat_h, 180);
    step_to(176); dly = 0;
    step_to(191); check("c191_overrun", 128'(overrunCount), 128'(1));
    check("c191_busy", 128'(busy), 128'(1));
    step_to(192);
    #2 rst = 1'b0;
    #1;
    check("async_notesOut", 128'(notesOut), 128'(0));
    check("async_lvStart", 128'(lvStart), 128'(0));
    check("async_busy", 128'(busy), 128'(0));
    check("async_overrun", 128'(overrunCount), 128'(0));
    check("async_timeoutErr", 128'(timeoutErr), 128'(0));
    check("async_state", 128'(dbg_state), 128'(0));
    watch_a2 = 1'b0;
    done_at  = -1;
    dly      = 5;
    step(); step();
    rst = 1'b1;
    cyc = 0;
`ifdef LV_REPEAT_FRAME_EN
    push_exp('0, 10);
`endif
    step_to(14); check("post_notesOut", 128'(notesOut), 128'(0));
    check("post_overrun", 128'(overrunCount), 128'(0));
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lv_frame_scheduler.md
# lv_frame_scheduler

Frame pacer and note snapshot buffer sitting directly upstream of the linear visualizer driver. Accepts note updates from the note-extraction pipeline at any rate, holds them in a shadow buffer, and at a fixed frame rate copies them to a stable output bank and issues a one-cycle start to the driver. Guarantees the driver's note inputs never change while a frame is being rendered, and reports overruns and driver timeouts.

## Interface
- BIN_QTY, 12, number of note bins
- FREQ, 12_000_000, clk frequency in Hz
- FRAME_HZ, 60, frame rate; PERIOD = FREQ / FRAME_HZ cycles (integer division, must be ≥ 4)
- TIMEOUT_CYCLES, 1_000_000, maximum cycles to wait for lvDone after lvStart
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- notesIn  in  Note [BIN_QTY]  new note set (CCHW::Note, treated as opaque)
- notesInValid  in  1  notesIn valid this cycle; single-cycle strobe
- clrErr  in  1  clears overrunCount and timeoutErr
- lvDone  in  1  driver frame complete (sampled only in WAIT)
- notesOut  out  Note [BIN_QTY]  stable note bank to driver
- lvStart  out  1  one-cycle driver start pulse
- busy  out  1  high in START and WAIT
- overrunCount  out  8  saturating count of ticks that landed in START/WAIT
- timeoutErr  out  1  sticky, driver failed to finish within TIMEOUT_CYCLES

## Operation
- Shadow buffer: on notesInValid, shadow ← notesIn and pending ← 1. The last write before a load wins.
- Tick counter: counts 0..PERIOD-1 and wraps. tick = (count == PERIOD-1). Free-running in all states.
- FSM states: IDLE, START, WAIT.
  - IDLE: on tick with pending set (see Configuration), load the bank: notesOut ← (notesInValid ? notesIn : shadow). Clear pending, unless notesInValid is also set in the same cycle, in which case pending is cleared and the data is forwarded. Go to START.
  - START: lvStart = 1 for exactly this cycle. Load the timeout counter with 0. Go to WAIT.
  - WAIT: increment the timeout counter. If lvDone = 1, go to IDLE. Otherwise, if the counter reaches TIMEOUT_CYCLES-1, set timeoutErr and go to IDLE.
- Any tick in START or WAIT: overrunCount increments, saturating at 255. The frame is skipped and pending is unchanged.
- notesOut changes only on the IDLE→START transition.
- clrErr clears overrunCount and timeoutErr. If clrErr and an increment occur in the same cycle, clearing wins.
- Reset (rst = 0, any time, including mid-frame): state = IDLE, tick counter = 0, pending = 0, shadow = 0, notesOut = all-zero, lvStart = 0, busy = 0, overrunCount = 0, timeoutErr = 0.

## Timing
- Tick in cycle t from IDLE: notesOut updates at the t→t+1 edge, and lvStart is high in cycle t+1.
- WAIT begins in cycle t+2. lvDone is ignored in START.
- A tick in cycle t with notesInValid in the same cycle t forwards notesIn (zero-cycle bypass).
- lvDone high in WAIT cycle n gives IDLE in cycle n+1. A tick in n+1 is serviced, so the minimum frame spacing is 3 cycles.
- All outputs are registered. lvStart, busy and notesOut have no combinational path from inputs.

## Configuration
- LV_REPEAT_FRAME_EN defined: every tick in IDLE starts a frame. If pending is clear, the existing notesOut is re-rendered unchanged. This keeps the LED strip refreshed.
- LV_REPEAT_FRAME_EN undefined: a tick in IDLE with pending = 0 is ignored. No lvStart is issued and overrunCount is unaffected.

## Test plan
Bench parameters: FREQ=1000, FRAME_HZ=100 (PERIOD=10), TIMEOUT_CYCLES=20, BIN_QTY=12.
- Basic frame:
  - Stimulus: after reset, pulse notesInValid with pattern A at cycle 3; driver model raises lvDone 5 cycles after lvStart.
  - Required: notesOut=A from cycle 10, lvStart only in cycle 10, busy in cycles 10–15, overrunCount=0.
- Last-write-wins:
  - Stimulus: write A at cycle 2 and B at cycle 5.
  - Required: the frame loads B; A never appears on notesOut.
- Bypass:
  - Stimulus: notesInValid with C in cycle 9, the tick cycle.
  - Required: notesOut=C at cycle 10 and pending=0 afterward.
- Overrun:
  - Stimulus: driver model delays lvDone by 15 cycles.
  - Required: the tick at cycle 19 is counted, overrunCount=1, notesOut unchanged until the next serviced tick.
- Timeout and clear:
  - Stimulus: driver model never asserts lvDone.
  - Required: timeoutErr=1 exactly 20 cycles after the WAIT entry, FSM returns to IDLE. A clrErr pulse gives timeoutErr=0 and overrunCount=0 the next cycle.
- Repeat and reset:
  - Stimulus: with no new data, observe the next tick.
  - Required: with LV_REPEAT_FRAME_EN, lvStart fires every 10 cycles with notesOut constant; without it, no lvStart.
  - Stimulus: assert rst during WAIT.
  - Required: all outputs are 0 immediately (asynchronous).
